wasm_cpu: RTL and testbench



---
 rtl/wasm_cpu.sv | 225 ++++++++++++++++++++++
 tb/tb_wasm_cpu.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/wasm_cpu.sv
// wasm_cpu: minimal WebAssembly stack-machine core.
// Fetches a 16-byte ROM window, executes one opcode every two cycles.
module wasm_cpu #(
  parameter bit HAS_FPU   = 1'b1,
  parameter bit USE_64B   = 1'b1,
  parameter int MEM_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  output logic [63:0]          result,
  output logic [1:0]           result_type,
  output logic                 result_empty,
  output logic [3:0]           trap,
  output logic [MEM_DEPTH:0]   mem_addr,
  output logic [3:0]           mem_extra,
  input  logic [127:0]         mem_data,
  input  logic                 mem_error
);

  localparam int AW = MEM_DEPTH + 1;

  localparam logic [3:0] TR_NONE  = 4'd0;
  localparam logic [3:0] TR_ENDED = 4'd1;
  localparam logic [3:0] TR_UNRCH = 4'd2;
  localparam logic [3:0] TR_UNDER = 4'd3;
  localparam logic [3:0] TR_OVER  = 4'd4;
  localparam logic [3:0] TR_INVAL = 4'd5;
  localparam logic [3:0] TR_MEM   = 4'd6;

  localparam logic [1:0] T_I32 = 2'd0;
  localparam logic [1:0] T_I64 = 2'd1;
  localparam logic [1:0] T_F32 = 2'd2;
  localparam logic [1:0] T_F64 = 2'd3;

  typedef enum logic [1:0] {FETCH, EXEC, HALT} state_t;

  state_t        state;
  logic [AW-1:0] pc;
  logic [4:0]    sp;
  logic [63:0]   stk_val [16];
  logic [1:0]    stk_typ [16];

  assign mem_addr  = pc;
  assign mem_extra = 4'd15;

  logic unused_bits;
  assign unused_bits = ^mem_data[127:88];

  logic [63:0] leb_val;
  logic [3:0]  leb_len;
  logic        leb_ok;

  // Signed LEB128 from window bytes 1..10, sign-extended to 64 bits.
  always_comb begin
    leb_val = '0;
    leb_len = 4'd10;
    leb_ok  = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (!leb_ok) begin
        leb_val = leb_val | (64'(mem_data[8*k+8 +: 7]) << (7*k));
        if (!mem_data[8*k+15]) begin
          leb_ok  = 1'b1;
          leb_len = 4'(k + 1);
          if (mem_data[8*k+14] && k < 9)
            leb_val = leb_val | ({64{1'b1}} << (7*k + 7));
        end
      end
    end
  end

  logic [7:0]  op;
  logic [3:0]  tos_i, nos_i;
  logic [63:0] a, b;
  logic [1:0]  ta, tb;

  assign op    = mem_data[7:0];
  assign tos_i = sp[3:0] - 4'd1;
  assign nos_i = sp[3:0] - 4'd2;
  assign a     = stk_val[nos_i];
  assign b     = stk_val[tos_i];
  assign ta    = stk_typ[nos_i];
  assign tb    = stk_typ[tos_i];

  logic [1:0]  need;
  logic        chk;
  logic [1:0]  want;
  logic        push;
  logic [63:0] pv;
  logic [1:0]  pt;
  logic [3:0]  tc;
  logic [4:0]  adv;
  logic [31:0] r32;
  logic [4:0]  base;
  logic [4:0]  nsp;

  always_comb begin
    need = 2'd0;
    chk  = 1'b0;
    want = T_I32;
    push = 1'b0;
    pv   = '0;
    pt   = T_I32;
    tc   = TR_NONE;
    adv  = 5'd1;
    r32  = '0;
    unique case (1'b1)
      op == 8'h00: tc = TR_UNRCH;
      op == 8'h01: adv = 5'd1;
      op == 8'h0b: tc = TR_ENDED;
      op == 8'h1a: need = 2'd1;
      op == 8'h41: begin
        push = 1'b1;
        pv   = {32'd0, leb_val[31:0]};
        adv  = 5'd1 + {1'b0, leb_len};
        if (!leb_ok || leb_len > 4'd5) tc = TR_INVAL;
      end
      op == 8'h42 && USE_64B: begin
        push = 1'b1;
        pv   = leb_val;
        pt   = T_I64;
        adv  = 5'd1 + {1'b0, leb_len};
        if (!leb_ok) tc = TR_INVAL;
      end
      op == 8'h43 && HAS_FPU: begin
        push = 1'b1;
        pv   = {32'd0, mem_data[39:8]};
        pt   = T_F32;
        adv  = 5'd5;
      end
      op == 8'h44 && HAS_FPU && USE_64B: begin
        push = 1'b1;
        pv   = mem_data[71:8];
        pt   = T_F64;
        adv  = 5'd9;
      end
      op == 8'h45: begin
        need = 2'd1;
        chk  = 1'b1;
        push = 1'b1;
        pv   = {63'd0, b[31:0] == 32'd0};
      end
      op inside {8'h46, 8'h47, 8'h6a, 8'h6b,
                 8'h6c, 8'h71, 8'h72, 8'h73}: begin
        need = 2'd2;
        chk  = 1'b1;
        push = 1'b1;
        case (op)
          8'h46:   r32 = {31'd0, a[31:0] == b[31:0]};
          8'h47:   r32 = {31'd0, a[31:0] != b[31:0]};
          8'h6a:   r32 = a[31:0] + b[31:0];
          8'h6b:   r32 = a[31:0] - b[31:0];
          8'h6c:   r32 = a[31:0] * b[31:0];
          8'h71:   r32 = a[31:0] & b[31:0];
          8'h72:   r32 = a[31:0] | b[31:0];
          default: r32 = a[31:0] ^ b[31:0];
        endcase
        pv = {32'd0, r32};
      end
      (op == 8'h7c || op == 8'h7d) && USE_64B: begin
        need = 2'd2;
        chk  = 1'b1;
        want = T_I64;
        push = 1'b1;
        pt   = T_I64;
        pv   = op[0] ? a - b : a + b;
      end
      default: tc = TR_INVAL;
    endcase
    base = sp - {3'd0, need};
    nsp  = base + {4'd0, push};
    if (tc == TR_NONE) begin
      if (sp < {3'd0, need}) tc = TR_UNDER;
      else if (chk && tb != want) tc = TR_INVAL;
      else if (chk && need == 2'd2 && ta != want) tc = TR_INVAL;
      else if (push && base == 5'd16) tc = TR_OVER;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= FETCH;
      pc           <= '0;
      sp           <= '0;
      result       <= '0;
      result_type  <= T_I32;
      result_empty <= 1'b1;
      trap         <= TR_NONE;
    end else begin
      unique case (state)
        FETCH: state <= EXEC;
        EXEC: begin
          if (mem_error) begin
            trap  <= TR_MEM;
            state <= HALT;
          end else if (tc != TR_NONE) begin
            trap  <= tc;
            state <= HALT;
          end else begin
            state <= FETCH;
            pc    <= pc + AW'(adv);
            sp    <= nsp;
            if (push) begin
              stk_val[base[3:0]] <= pv;
              stk_typ[base[3:0]] <= pt;
              result             <= pv;
              result_type        <= pt;
              result_empty       <= 1'b0;
            end else if (need != 2'd0) begin
              if (base == 5'd0) begin
                result       <= '0;
                result_type  <= T_I32;
                result_empty <= 1'b1;
              end else begin
                result      <= stk_val[base[3:0] - 4'd1];
                result_type <= stk_typ[base[3:0] - 4'd1];
              end
            end
          end
        end
        default: state <= HALT;
      endcase
    end
  end

endmodule

// File: tb/tb_wasm_cpu.sv
// tb_wasm_cpu: directed programs with a queue-based scoreboard.
// Monitor compares the visible stack/trap state whenever the core halts.
module tb_wasm_cpu;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [63:0]  result;
  logic [1:0]   result_type;
  logic         result_empty;
  logic [3:0]   trap;
  logic [4:0]   mem_addr;
  logic [3:0]   mem_extra;
  logic [127:0] mem_data = '0;
  logic         mem_error = 1'b0;

  always #5 clk = ~clk;

  wasm_cpu dut (
    .clk(clk), .reset(reset), .result(result),
    .result_type(result_type), .result_empty(result_empty),
    .trap(trap), .mem_addr(mem_addr), .mem_extra(mem_extra),
    .mem_data(mem_data), .mem_error(mem_error)
  );

  logic [7:0] rom [32];
  logic       force_err = 1'b0;

  // Circular 32-byte ROM, registered window.
  always @(posedge clk) begin
    for (int k = 0; k < 16; k++)
      mem_data[8*k +: 8] <= rom[mem_addr + 5'(k)];
    mem_error <= force_err;
  end

  typedef struct {
    logic [63:0] r;
    logic [1:0]  t;
    logic        e;
    logic [3:0]  tr;
    string       nm;
  } exp_t;

  exp_t       exp_q [$];
  logic [7:0] pq [$];
  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, req);
    end
  endtask

  task automatic load();
    for (int i = 0; i < 32; i++)
      rom[i] = (i < pq.size()) ? pq[i] : 8'h00;
  endtask

  task automatic rstchk(input string nm);
    check({nm, "_res"}, result, 64'd0);
    check({nm, "_typ"}, 64'(result_type), 64'd0);
    check({nm, "_emp"}, 64'(result_empty), 64'd1);
    check({nm, "_trap"}, 64'(trap), 64'd0);
    check({nm, "_pc"}, 64'(mem_addr), 64'd0);
  endtask

  task automatic go(input string nm, input logic [63:0] r,
                    input logic [1:0] t, input logic e,
                    input logic [3:0] tr);
    int tgt;
    exp_t x;
    @(negedge clk);
    reset = 1'b1;
    load();
    @(negedge clk);
    x.r = r; x.t = t; x.e = e; x.tr = tr; x.nm = nm;
    exp_q.push_back(x);
    tgt = done_cnt + 1;
    reset = 1'b0;
    for (int c = 0; c < 200 && done_cnt < tgt; c++) @(negedge clk);
    if (done_cnt < tgt) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: trap=%0d want %0d", nm, trap, tr);
      exp_q.delete();
    end
  endtask

  logic [3:0] prev_trap = 4'd0;

  initial forever begin
    @(negedge clk);
    if (!reset && trap != 4'd0 && prev_trap == 4'd0) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_halt: trap=%0d want none", trap);
      end else begin
        exp_t x;
        x = exp_q.pop_front();
        check({x.nm, "_res"}, result, x.r);
        check({x.nm, "_typ"}, 64'(result_type), 64'(x.t));
        check({x.nm, "_emp"}, 64'(result_empty), 64'(x.e));
        check({x.nm, "_trap"}, 64'(trap), 64'(x.tr));
      end
      done_cnt++;
    end
    prev_trap = trap;
  end

  initial begin
    reset = 1'b1;
    repeat (2) @(negedge clk);
    rstchk("por");
    check("extra", 64'(mem_extra), 64'd15);

    pq = {8'h41, 8'h03, 8'h41, 8'h02, 8'h6b, 8'h0b};
    go("sub", 64'd1, 2'd0, 1'b0, 4'd1);
    pq = {8'h41, 8'h00, 8'h41, 8'h01, 8'h6b, 8'h0b};
    go("subneg", 64'h0000_0000_FFFF_FFFF, 2'd0, 1'b0, 4'd1);
    pq = {8'h41, 8'h7f, 8'h41, 8'h01, 8'h6a, 8'h0b};
    go("addwrap", 64'd0, 2'd0, 1'b0, 4'd1);
    pq = {8'h42, 8'h05, 8'h42, 8'h07, 8'h7d, 8'h0b};
    go("i64sub", 64'hFFFF_FFFF_FFFF_FFFE, 2'd1, 1'b0, 4'd1);
    pq = {8'h42, 8'h7f, 8'h42, 8'h01, 8'h7c, 8'h0b};
    go("i64add", 64'd0, 2'd1, 1'b0, 4'd1);
    pq = {8'h6a};
    go("under", 64'd0, 2'd0, 1'b1, 4'd3);
    pq = {8'h41, 8'h06, 8'h41, 8'h07, 8'h6c, 8'h0b};
    go("mul", 64'd42, 2'd0, 1'b0, 4'd1);
    pq = {8'h41, 8'h0c, 8'h41, 8'h0a, 8'h71, 8'h41, 8'h03, 8'h72, 8'h0b};
    go("andor", 64'd11, 2'd0, 1'b0, 4'd1);
    pq = {8'h41, 8'h0c, 8'h41, 8'h0a, 8'h73, 8'h0b};
    go("xor", 64'd6, 2'd0, 1'b0, 4'd1);
    pq = {8'h41, 8'h05, 8'h41, 8'h05, 8'h46, 8'h41, 8'h01, 8'h47, 8'h0b};
    go("eqne", 64'd0, 2'd0, 1'b0, 4'd1);
    pq = {8'h41, 8'h00, 8'h45, 8'h0b};
    go("eqz", 64'd1, 2'd0, 1'b0, 4'd1);
    pq = {8'h41, 8'hff, 8'h7e, 8'h41, 8'h80, 8'h01, 8'h6a, 8'h0b};
    go("leb", 64'h0000_0000_FFFF_FFFF, 2'd0, 1'b0, 4'd1);
    pq = {8'h41, 8'h01, 8'h42, 8'h01, 8'h6a};
    go("tmix", 64'd1, 2'd1, 1'b0, 4'd5);
    pq = {8'h43, 8'h00, 8'h00, 8'h80, 8'h3f, 8'h0b};
    go("f32", 64'h0000_0000_3F80_0000, 2'd2, 1'b0, 4'd1);
    pq = {8'h44, 8'h00, 8'h00, 8'h00, 8'h00,
          8'h00, 8'h00, 8'hf0, 8'h3f, 8'h0b};
    go("f64", 64'h3FF0_0000_0000_0000, 2'd3, 1'b0, 4'd1);
    pq = {8'h41, 8'h05, 8'h41, 8'h06, 8'h1a, 8'h0b};
    go("drop", 64'd5, 2'd0, 1'b0, 4'd1);
    pq = {8'h41, 8'h05, 8'h1a, 8'h0b};
    go("dropempty", 64'd0, 2'd0, 1'b1, 4'd1);
    pq = {8'hff};
    go("badop", 64'd0, 2'd0, 1'b1, 4'd5);

    pq.delete();
    for (int i = 0; i < 16; i++) begin
      pq.push_back(8'h41);
      pq.push_back(8'h01);
    end
    go("over", 64'd1, 2'd0, 1'b0, 4'd4);

    pq = {8'h41, 8'h05, 8'h00};
    go("unreach", 64'd5, 2'd0, 1'b0, 4'd2);
    repeat (5) @(negedge clk);
    check("frz_trap", 64'(trap), 64'd2);
    check("frz_res", result, 64'd5);
    check("frz_pc", 64'(mem_addr), 64'd2);

    force_err = 1'b1;
    pq = {8'h01};
    go("memerr", 64'd0, 2'd0, 1'b1, 4'd6);
    force_err = 1'b0;

    pq = {8'h41, 8'h03, 8'h41, 8'h02, 8'h6b, 8'h0b};
    @(negedge clk);
    reset = 1'b1;
    load();
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    rstchk("mid");
    go("rerun", 64'd1, 2'd0, 1'b0, 4'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
